// File: rtl/psum_drain_collector_pkg.sv
// Shared widths and helpers for the GEMV partial-sum drain path.
// Imported by the collector, its FIFO and the array controller.
package psum_drain_collector_pkg;

  function automatic int sum_w(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int vec_w(input int data_width,
                               input int cols);
    return 2 * data_width * cols;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Result-vector FIFO with a registered head and sticky overflow.
// Ports: push/wdata in, out_ready/out_valid/rdata out, count, overflow.
module sync_fifo
  import psum_drain_collector_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [width-1:0]        wdata,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [width-1:0]        rdata,
  output logic [clog2(depth):0]   count,
  output logic                    overflow
);

  localparam int AW = clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [CW-1:0]    cnt_pop;
  logic [AW-1:0]    rd_next;
  logic [width-1:0] head_nxt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(depth));
  assign do_pop  = out_ready && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign cnt_pop = cnt - CW'(do_pop);
  assign rd_next = rd_ptr + AW'(do_pop);

  // Head register is preloaded with whatever will sit at the
  // read pointer after this edge; an entry written into a
  // FIFO that drains empty this edge comes straight from wdata.
  assign head_nxt = (do_push && cnt_pop == '0) ? wdata
                  : mem[rd_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(do_push);
      cnt    <= cnt_pop + CW'(do_push);
      if (do_push || cnt_pop != '0) rdata <= head_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign out_valid = !empty;
  assign count     = cnt;

endmodule

// File: rtl/psum_drain_collector.sv
// De-skews bottom-row PE column sums into aligned result vectors.
// Ports: sum_valid/in_sum in, out_valid/out_ready/out_sum, count.
module psum_drain_collector
  import psum_drain_collector_pkg::*;
#(
  parameter int data_width         = 19,
  parameter int w_tile_column_size = 2,
  parameter int fifo_depth         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sum_valid,
  input  logic [vec_w(data_width, w_tile_column_size)-1:0] in_sum,
  output logic out_valid,
  input  logic out_ready,
  output logic [vec_w(data_width, w_tile_column_size)-1:0] out_sum,
  output logic [clog2(fifo_depth):0] fifo_count,
  output logic overflow
);

  localparam int SW = sum_w(data_width);
  localparam int VW = vec_w(data_width, w_tile_column_size);
  localparam int N  = w_tile_column_size;

  logic [VW-1:0] aligned;
  logic          aligned_valid;

  // Column c arrives c cycles late, so it waits N-1-c cycles
  // to line up with the last column.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*SW +: SW] = in_sum[c*SW +: SW];
    end else begin : g_dly
      logic [SW-1:0] dl [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) dl[i] <= '0;
        end else begin
          dl[0] <= in_sum[c*SW +: SW];
          for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
        end
      end
      assign aligned[c*SW +: SW] = dl[D-1];
    end
  end

  if (N == 1) begin : g_vld_pass
    assign aligned_valid = sum_valid;
  end else begin : g_vld_dly
    logic [N-2:0] vld;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
      end else if (clear) begin
        vld <= '0;
      end else begin
        vld <= (vld << 1) | (N-1)'(sum_valid);
      end
    end
    assign aligned_valid = vld[N-2];
  end

  sync_fifo #(
    .width (VW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (aligned_valid),
    .wdata     (aligned),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .rdata     (out_sum),
    .count     (fifo_count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed self-checking bench for psum_drain_collector.
// Two columns of 38-bit sums, four-entry FIFO.
module tb_psum_drain_collector;

  localparam int DW  = 19;
  localparam int N   = 2;
  localparam int DEP = 4;
  localparam int SW  = 2 * DW;
  localparam int VW  = SW * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          sum_valid;
  logic [VW-1:0] in_sum;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_sum;
  logic [2:0]    fifo_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_drain_collector #(
    .data_width         (DW),
    .w_tile_column_size (N),
    .fifo_depth         (DEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .sum_valid  (sum_valid),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input int c0,
                       input int c1, input logic rdy);
    sum_valid = sv;
    in_sum    = {SW'(c1), SW'(c0)};
    out_ready = rdy;
  endtask

  task automatic do_clear();
    drive(1'b0, 0, 0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    checks++;
    if (out_sum !== '0) begin
      errors++;
      $display("FAIL reset_sum got %h want 0", out_sum);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", fifo_count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %0b want 0", overflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [VW-1:0] exp;
    exp = {SW'(2), SW'(1)};
    do_clear();
    drive(1'b1, 1, 0, 1'b1);
    step();
    drive(1'b0, 0, 2, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %0b want 0", out_valid);
    end
    step();
    drive(1'b0, 0, 0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got %0b want 1", out_valid);
    end
    checks++;
    if (out_sum !== exp) begin
      errors++;
      $display("FAIL single_sum got %h want %h", out_sum, exp);
    end
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_cnt1 got %0d want 1", fifo_count);
    end
    step();
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got cnt=%0d v=%0b want 0 0",
               fifo_count, out_valid);
    end
  endtask

  task automatic test_burst();
    int idx;
    logic [VW-1:0] exp;
    do_clear();
    for (int t = 0; t < 7; t++) begin
      drive(t < 6, (t < 6) ? 'h10 + t : 0,
            (t >= 1) ? 'h20 + t - 1 : 0, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 1'b0);
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL burst_cnt got %0d want 4", fifo_count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL burst_ovf got %0b want 1", overflow);
    end
    idx = 0;
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 0, 0, 1'b1);
      if (out_valid) begin
        exp = {SW'('h20 + idx), SW'('h10 + idx)};
        checks++;
        if (out_sum !== exp) begin
          errors++;
          $display("FAIL burst_data%0d got %h want %h",
                   idx, out_sum, exp);
        end
        idx++;
      end
      step();
    end
    checks++;
    if (idx !== 4) begin
      errors++;
      $display("FAIL burst_n got %0d want 4", idx);
    end
    checks++;
    if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL burst_end got cnt=%0d ovf=%0b want 0 1",
               fifo_count, overflow);
    end
    do_clear();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_clr got %0b want 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    int idx;
    int e0 [5];
    int e1 [5];
    logic rdy;
    logic [VW-1:0] exp;
    e0 = '{'h30, 'h31, 'h32, 'h33, 'h35};
    e1 = '{'h40, 'h41, 'h42, 'h43, 'h45};
    do_clear();
    idx = 0;
    for (int t = 0; t < 16; t++) begin
      rdy = (t == 6) || (t >= 8);
      drive((t < 4) || (t == 5),
            (t < 4) ? 'h30 + t : ((t == 5) ? 'h35 : 0),
            (t >= 1 && t <= 4) ? 'h40 + t - 1
              : ((t == 6) ? 'h45 : 0),
            rdy);
      if (t == 7) begin
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fullpop_cnt got cnt=%0d ovf=%0b want 4 0",
                   fifo_count, overflow);
        end
      end
      if (out_valid && rdy && idx < 5) begin
        exp = {SW'(e1[idx]), SW'(e0[idx])};
        checks++;
        if (out_sum !== exp) begin
          errors++;
          $display("FAIL fullpop_data%0d got %h want %h",
                   idx, out_sum, exp);
        end
        idx++;
      end
      step();
    end
    checks++;
    if (idx !== 5 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL fullpop_end got n=%0d cnt=%0d want 5 0",
               idx, fifo_count);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    logic rdy;
    logic [VW-1:0] exp;
    do_clear();
    idx = 0;
    for (int t = 0; t < 30; t++) begin
      rdy = (t % 2) == 0;
      drive(t < 8, (t < 8) ? t + 1 : 0,
            (t >= 1 && t <= 8) ? 'h100 + t : 0, rdy);
      if (out_valid && rdy) begin
        exp = {SW'('h100 + idx + 1), SW'(idx + 1)};
        checks++;
        if (out_sum !== exp) begin
          errors++;
          $display("FAIL bp_data%0d got %h want %h",
                   idx, out_sum, exp);
        end
        idx++;
      end
      step();
    end
    checks++;
    if (idx !== 8) begin
      errors++;
      $display("FAIL bp_n got %0d want 8", idx);
    end
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL bp_end got ovf=%0b cnt=%0d want 0 0",
               overflow, fifo_count);
    end
  endtask

  task automatic test_clear();
    int seen;
    do_clear();
    drive(1'b1, 'h55, 0, 1'b1);
    step();
    drive(1'b1, 'h57, 'h66, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 0, 'h68, 1'b1);
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) seen++;
      step();
      drive(1'b0, 0, 0, 1'b1);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL clear_valid got %0d busy cycles want 0", seen);
    end
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_end got ovf=%0b cnt=%0d want 0 0",
               overflow, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] exp;
    do_clear();
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 'h70 + t, (t >= 1) ? 'h80 + t - 1 : 0, 1'b0);
      step();
    end
    drive(1'b0, 0, 'h83, 1'b0);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL arst_pre got %0d want 3", fifo_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 ||
        overflow !== 1'b0 || out_sum !== '0) begin
      errors++;
      $display("FAIL arst_now got v=%0b cnt=%0d ovf=%0b sum=%h want 0",
               out_valid, fifo_count, overflow, out_sum);
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_stale got %0b want 0", out_valid);
    end
    drive(1'b1, 'h99, 0, 1'b1);
    step();
    drive(1'b0, 0, 'hAA, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b1);
    exp = {SW'('hAA), SW'('h99)};
    checks++;
    if (out_valid !== 1'b1 || out_sum !== exp) begin
      errors++;
      $display("FAIL arst_new got v=%0b sum=%h want 1 %h",
               out_valid, out_sum, exp);
    end
    step();
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL arst_drain got %0d want 0", fifo_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_pop();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_drain_collector.md
Name: psum_drain_collector

Overview:
- Sits below the last PE row of the systolic GEMV array and terminates the partial-sum chain.
- The bottom row emits one 2*data_width sum per column. Column c of a given result vector appears c cycles after column 0, because the activation skews one PE per cycle.
- The block de-skews the columns into one aligned result vector and buffers it in a small FIFO.
- The buffered vector is handed to the writeback path over a valid/ready handshake.

Parameters:
- data_width, 19, operand width; each column sum is 2*data_width bits.
- w_tile_column_size, 2, number of PE columns (>=1).
- fifo_depth, 4, result-vector entries buffered; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of delay lines, FIFO and error flag.
- sum_valid  input  1  column 0 of in_sum carries a valid sum this cycle.
- in_sum  input  data_width*2*w_tile_column_size  bottom-row out_sum bus; column i occupies bits [(i+1)*2*data_width-1 : i*2*data_width].
- out_valid  output  1  FIFO head holds an aligned vector.
- out_ready  input  1  consumer accepts the head this cycle.
- out_sum  output  data_width*2*w_tile_column_size  aligned vector, same column packing as in_sum.
- fifo_count  output  clog2(fifo_depth)+1  occupied entries.
- overflow  output  1  sticky: an aligned vector was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_sum=0, fifo_count=0, overflow=0.
  - All delay-line data and valid bits are cleared.
- Skew model: when sum_valid=1 in cycle T, column c of the same vector is present on in_sum in cycle T+c.
- Per-column delay:
  - Column c passes through (w_tile_column_size-1-c) registers.
  - The last column (c = w_tile_column_size-1) is unregistered.
  - The valid tag is sum_valid delayed by w_tile_column_size-1 cycles.
  - Result: all columns are aligned in cycle T+w_tile_column_size-1.
- Push: the aligned vector is written at the clock edge ending cycle T+w_tile_column_size-1. If the FIFO was empty, out_valid=1 in cycle T+w_tile_column_size.
- Throughput: back-to-back sum_valid (one vector per cycle) is supported with no bubbles.
- Pop: when out_valid && out_ready, the head is retired at the edge. out_sum is registered and shows the new head (or holds its last value when empty) one cycle later.
- No FIFO bypass: the minimum input-to-output latency is w_tile_column_size cycles.
- Full FIFO:
  - A push together with a pop in the same cycle is accepted, and fifo_count is unchanged.
  - A push without a pop is dropped, overflow is set to 1, and FIFO contents are unchanged.
- Empty FIFO: out_ready is ignored and fifo_count stays 0.
- overflow stays 1 until clear or reset.
- clear=1:
  - Takes priority over push, pop and sum_valid in the same cycle.
  - Next cycle: fifo_count=0, out_valid=0, overflow=0, all in-flight valid tags are 0.
  - Data registers are don't-care.
- Reset mid-operation: same effect as clear, but asynchronous; partially de-skewed vectors are lost.
- Arithmetic: none. Sums pass bit-exact, with no sign extension or truncation.
- Pointers: read and write pointers are clog2(fifo_depth) bits and wrap modulo fifo_depth. fifo_count is tracked separately so that full and empty are unambiguous.

Decomposition:
- Shared package holds:
  - function sum_w(data_width) = 2*data_width.
  - function vec_w(data_width, cols) = 2*data_width*cols.
  - clog2 helper, reused by the array controller.
- Sub-module sync_fifo (parameters width, depth): holds the push/pop/full/empty/count logic.
- The de-skew delay lines stay in the top module inside a generate loop over columns.

Test Plan (data_width=19, w_tile_column_size=2, fifo_depth=4):
- Single vector: sum_valid=1 at cycle 0 with col0=38'h1; col1=38'h2 at cycle 1; out_ready=1 -> out_valid=1 at cycle 2, out_sum={38'h2,38'h1}, fifo_count=0 at cycle 3.
- Burst: 6 vectors on consecutive cycles with out_ready=0 -> fifo_count saturates at 4, overflow=1, and the first 4 vectors drain in order after out_ready=1.
- Full plus simultaneous pop: FIFO holds 4, out_ready=1 on the same cycle a 5th vector aligns -> fifo_count stays 4, overflow stays 0, 5th vector is output last.
- Backpressure toggling: out_ready alternates 1/0 across 8 vectors (values 1..8 in col0, 0x100+k in col1) -> output order and data are exact and no vector is lost.
- clear mid-flight: sum_valid at cycle 0, clear at cycle 1 -> out_valid never rises for that vector; overflow and fifo_count are 0.
- Async reset while fifo_count=3: rst_n low for 1 cycle mid-burst -> all outputs are 0 immediately; a new vector after release appears 2 cycles after its sum_valid.
